// File: rtl/spi_master.sv
// spi_master: single-word SPI bus master with selectable CPOL/CPHA and an integer SCLK divider.
// Define SPI_MASTER_MISO_SYNC_EN to pass spi_miso through a two-flop synchronizer.
module spi_master #(
  parameter int unsigned C_DATA_WIDTH = 8,
  parameter int unsigned C_CLK_DIV    = 4,
  parameter bit          C_CPOL       = 1'b0,
  parameter bit          C_CPHA       = 1'b0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [C_DATA_WIDTH-1:0] s_tx_data,
  input  logic                    s_tx_valid,
  output logic                    s_tx_ready,
  output logic [C_DATA_WIDTH-1:0] m_rx_data,
  output logic                    m_rx_valid,
  output logic                    busy,
  output logic                    spi_cs_n,
  output logic                    spi_sclk,
  output logic                    spi_mosi,
  input  logic                    spi_miso
);

  localparam int unsigned CW = $clog2(C_CLK_DIV);
  localparam int unsigned HW = $clog2(2 * C_DATA_WIDTH);
  localparam logic [CW-1:0] CNT_LAST  = CW'(C_CLK_DIV - 1);
  localparam logic [HW-1:0] HALF_LAST = HW'(2 * C_DATA_WIDTH - 1);

  typedef enum logic [2:0] {IDLE, LEAD, SHIFT, TRAIL, GAP} state_t;

  state_t                  state;
  logic [CW-1:0]           cnt;
  logic [HW-1:0]           half;
  logic [HW-1:0]           half_nxt;
  logic [C_DATA_WIDTH-1:0] tx_sh;
  logic [C_DATA_WIDTH-1:0] rx_sh;
  logic                    wrap;
  logic                    edge_go;
  logic                    lead_edge;
  logic                    shift_ev;
  logic                    sample_ev;
  logic                    cap_en;
  logic                    cap_bit;

  assign s_tx_ready = (state == IDLE);
  assign busy       = (state != IDLE);
  assign wrap       = (cnt == CNT_LAST);

  // edge_go marks the clk edge that toggles SCLK; half_nxt is the half-period it opens.
  always_comb begin
    edge_go   = wrap && ((state == LEAD) || ((state == SHIFT) && (half != HALF_LAST)));
    half_nxt  = (state == LEAD) ? '0 : half + HW'(1);
    lead_edge = ~half_nxt[0];
    if (C_CPHA) begin
      shift_ev  = edge_go && lead_edge;
      sample_ev = edge_go && !lead_edge;
    end else begin
      shift_ev  = edge_go && !lead_edge && (half_nxt != HALF_LAST);
      sample_ev = edge_go && lead_edge;
    end
  end

`ifdef SPI_MASTER_MISO_SYNC_EN
  (* ASYNC_REG = "TRUE" *) logic miso_s1;
  (* ASYNC_REG = "TRUE" *) logic miso_s2;
  logic [1:0] smp_d;

  if (C_CLK_DIV < 3) begin : g_div_check
    $error("spi_master: C_CLK_DIV must be at least 3 when SPI_MASTER_MISO_SYNC_EN is defined");
  end

  // Sample strobe is delayed by the synchronizer depth so it lines up with miso_s2.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      miso_s1 <= 1'b0;
      miso_s2 <= 1'b0;
      smp_d   <= '0;
    end else begin
      miso_s1 <= spi_miso;
      miso_s2 <= miso_s1;
      smp_d   <= {smp_d[0], sample_ev};
    end
  end

  assign cap_en  = smp_d[1];
  assign cap_bit = miso_s2;
`else
  assign cap_en  = sample_ev;
  assign cap_bit = spi_miso;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      half       <= '0;
      tx_sh      <= '0;
      rx_sh      <= '0;
      m_rx_data  <= '0;
      m_rx_valid <= 1'b0;
      spi_cs_n   <= 1'b1;
      spi_sclk   <= C_CPOL;
      spi_mosi   <= 1'b0;
    end else begin
      m_rx_valid <= 1'b0;
      cnt        <= ((state == IDLE) || wrap) ? '0 : cnt + CW'(1);
      if (cap_en) rx_sh <= {rx_sh[C_DATA_WIDTH-2:0], cap_bit};
      if (shift_ev) begin
        spi_mosi <= tx_sh[C_DATA_WIDTH-1];
        tx_sh    <= tx_sh << 1;
      end
      if (edge_go) begin
        spi_sclk <= ~spi_sclk;
        half     <= half_nxt;
      end
      unique case (state)
        IDLE: if (s_tx_valid) begin
          state    <= LEAD;
          spi_cs_n <= 1'b0;
          rx_sh    <= '0;
          if (C_CPHA) begin
            tx_sh <= s_tx_data;
          end else begin
            tx_sh    <= s_tx_data << 1;
            spi_mosi <= s_tx_data[C_DATA_WIDTH-1];
          end
        end
        LEAD:  if (wrap) state <= SHIFT;
        SHIFT: if (wrap && (half == HALF_LAST)) state <= TRAIL;
        TRAIL: if (wrap) begin
          state      <= GAP;
          spi_cs_n   <= 1'b1;
          spi_mosi   <= 1'b0;
          m_rx_data  <= rx_sh;
          m_rx_valid <= 1'b1;
        end
        GAP:     if (wrap) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master.sv
// tb_spi_master: mode-0 and mode-3 masters against behavioural SPI slaves, scoreboard-checked.
`timescale 1ns/1ps
module tb_spi_master;

  localparam int unsigned W = 8;
`ifdef SPI_MASTER_MISO_SYNC_EN
  localparam int unsigned DIV0 = 3;
`else
  localparam int unsigned DIV0 = 4;
`endif
  localparam int unsigned DIV1 = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [W-1:0] txd0, txd1, rxd0, rxd1;
  logic txv0, txv1, rdy0, rdy1, rxv0, rxv1, busy0, busy1;
  logic cs0, cs1, sck0, sck1, mo0, mo1;
  logic [1:0] miso = '0;

  spi_master #(.C_DATA_WIDTH(W), .C_CLK_DIV(DIV0), .C_CPOL(1'b0), .C_CPHA(1'b0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .s_tx_data(txd0), .s_tx_valid(txv0), .s_tx_ready(rdy0),
    .m_rx_data(rxd0), .m_rx_valid(rxv0), .busy(busy0), .spi_cs_n(cs0), .spi_sclk(sck0),
    .spi_mosi(mo0), .spi_miso(miso[0]));

  spi_master #(.C_DATA_WIDTH(W), .C_CLK_DIV(DIV1), .C_CPOL(1'b1), .C_CPHA(1'b1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .s_tx_data(txd1), .s_tx_valid(txv1), .s_tx_ready(rdy1),
    .m_rx_data(rxd1), .m_rx_valid(rxv1), .busy(busy1), .spi_cs_n(cs1), .spi_sclk(sck1),
    .spi_mosi(mo1), .spi_miso(miso[1]));

  logic [1:0] cs_v, sck_v, mo_v, rxv_v, rdy_v, busy_v;
  assign cs_v   = {cs1, cs0};
  assign sck_v  = {sck1, sck0};
  assign mo_v   = {mo1, mo0};
  assign rxv_v  = {rxv1, rxv0};
  assign rdy_v  = {rdy1, rdy0};
  assign busy_v = {busy1, busy0};

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int unsigned div_of(input int i);
    return (i == 0) ? DIV0 : DIV1;
  endfunction
  function automatic logic mode3(input int i);
    return (i == 1);
  endfunction
  function automatic logic [W-1:0] rxd_of(input int i);
    return (i == 0) ? rxd0 : rxd1;
  endfunction

  logic [W-1:0] exp_mosi[$];
  logic [W-1:0] exp_rx[$];

  // Slave model and output monitor state, one slot per DUT.
  logic [W-1:0] sl_word [2] = '{8'h00, 8'h00};
  logic [W-1:0] sreg [2] = '{8'h00, 8'h00};
  logic [W-1:0] cap [2] = '{8'h00, 8'h00};
  int unsigned bits [2] = '{0, 0};
  int unsigned lowcnt [2] = '{0, 0};
  int unsigned hicnt [2] = '{1000, 1000};
  int unsigned acc_cnt [2] = '{0, 0};
  int unsigned vwidth [2] = '{0, 0};
  int unsigned vcount [2] = '{0, 0};
  int unsigned viol [2] = '{0, 0};
  logic [1:0] cs_p = '1, sck_p = 2'b10, mo_p = '0, rxv_p = '0, busy_p = '0, rdy_p = '1;

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst_n) begin
        if (!cs_v[i] && cs_p[i]) begin
          check($sformatf("cs_gap%0d(%0d)", i, hicnt[i]), 32'(hicnt[i] >= div_of(i) + 1), 1);
          bits[i]   = 0;
          cap[i]    = '0;
          lowcnt[i] = 1;
          if (mode3(i)) begin
            sreg[i] = sl_word[i];
          end else begin
            miso[i] = sl_word[i][W-1];
            sreg[i] = sl_word[i] << 1;
          end
        end else if (!cs_v[i]) begin
          lowcnt[i]++;
          if (sck_v[i] && !sck_p[i]) begin
            if (mo_v[i] !== mo_p[i]) viol[i]++;
            cap[i] = {cap[i][W-2:0], mo_v[i]};
            bits[i]++;
          end
          if (!sck_v[i] && sck_p[i]) begin
            miso[i] = sreg[i][W-1];
            sreg[i] = sreg[i] << 1;
          end
        end else if (!cs_p[i] && bits[i] == W) begin
          check($sformatf("cs_low_len%0d", i), lowcnt[i], (2 * W + 2) * div_of(i));
          if (exp_mosi.size() == 0) check($sformatf("mosi_q_underflow%0d", i), 1, 0);
          else check($sformatf("mosi_word%0d", i), cap[i], exp_mosi.pop_front());
        end

        if (busy_v[i] && !busy_p[i]) acc_cnt[i] = 0;
        else acc_cnt[i]++;

        if (rxv_v[i] && !rxv_p[i]) begin
          vcount[i]++;
          vwidth[i] = 1;
          check($sformatf("rx_valid_lat%0d", i), acc_cnt[i], (2 * W + 2) * div_of(i));
          if (exp_rx.size() == 0) check($sformatf("rx_q_underflow%0d", i), 1, 0);
          else check($sformatf("rx_data%0d", i), rxd_of(i), exp_rx.pop_front());
        end else if (rxv_v[i]) begin
          vwidth[i]++;
        end
        if (!rxv_v[i] && rxv_p[i]) check($sformatf("rx_valid_width%0d", i), vwidth[i], 1);

        if (rdy_v[i] && !rdy_p[i])
          check($sformatf("ready_lat%0d", i), acc_cnt[i], (2 * W + 3) * div_of(i));
      end
      hicnt[i] = cs_v[i] ? hicnt[i] + 1 : 0;
      cs_p[i]   = cs_v[i];
      sck_p[i]  = sck_v[i];
      mo_p[i]   = mo_v[i];
      rxv_p[i]  = rxv_v[i];
      busy_p[i] = busy_v[i];
      rdy_p[i]  = rdy_v[i];
    end
  end

  task automatic drive(input int i, input logic v, input logic [W-1:0] d);
    if (i == 0) begin txv0 = v; txd0 = d; end
    else begin txv1 = v; txd1 = d; end
  endtask

  task automatic wait_level(input string tag, input int i, input logic want_busy);
    int unsigned t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (busy_v[i] !== want_busy && t < 500);
    check(tag, busy_v[i], want_busy);
  endtask

  task automatic send(input int i, input logic [W-1:0] d, input logic [W-1:0] ret);
    int unsigned vc = vcount[i];
    sl_word[i] = ret;
    exp_mosi.push_back(d);
    exp_rx.push_back(ret);
    @(negedge clk);
    drive(i, 1'b1, d);
    wait_level("accept_wait", i, 1'b1);
    drive(i, 1'b0, d);
    wait_level("done_wait", i, 1'b0);
    repeat (2) @(negedge clk);
    check($sformatf("rx_pulses%0d", i), vcount[i] - vc, 1);
  endtask

  initial begin
    int unsigned vc, edges, t;
    logic prev;
    drive(0, 1'b0, '0);
    drive(1, 1'b0, '0);
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check("rst_cs_n", cs_v[i], 1);
      check("rst_sclk", sck_v[i], mode3(i));
      check("rst_mosi", mo_v[i], 0);
      check("rst_rx_valid", rxv_v[i], 0);
      check("rst_rx_data", rxd_of(i), 0);
      check("rst_busy", busy_v[i], 0);
      check("rst_ready", rdy_v[i], 1);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    send(0, 8'hA5, 8'h3C);
    send(1, 8'h5A, 8'hC3);
    check("m3_sclk_idle", sck1, 1);
    send(0, 8'h00, 8'h96);

    // back-to-back with valid held; data changes while busy
    vc = vcount[0];
    sl_word[0] = 8'h33;
    exp_mosi.push_back(8'h01); exp_mosi.push_back(8'h80);
    exp_rx.push_back(8'h33);   exp_rx.push_back(8'hCC);
    @(negedge clk);
    drive(0, 1'b1, 8'h01);
    wait_level("b2b_accept1", 0, 1'b1);
    @(negedge clk);
    sl_word[0] = 8'hCC;
    drive(0, 1'b1, 8'h80);
    wait_level("b2b_idle1", 0, 1'b0);
    wait_level("b2b_accept2", 0, 1'b1);
    drive(0, 1'b0, 8'h80);
    wait_level("b2b_done", 0, 1'b0);
    repeat (2) @(negedge clk);
    check("b2b_pulses", vcount[0] - vc, 2);

    // abort after the third SCLK edge
    vc = vcount[0];
    sl_word[0] = 8'h5C;
    @(negedge clk);
    drive(0, 1'b1, 8'hA5);
    wait_level("abort_accept", 0, 1'b1);
    drive(0, 1'b0, 8'hA5);
    edges = 0; t = 0; prev = sck0;
    while (edges < 3 && t < 500) begin
      @(negedge clk);
      t++;
      if (sck0 !== prev) edges++;
      prev = sck0;
    end
    check("abort_edges", edges, 3);
    check("abort_sclk_pre", sck0, 1);
    #2 rst_n = 1'b0;
    #1;
    check("abort_cs_n", cs0, 1);
    check("abort_sclk", sck0, 0);
    check("abort_busy", busy0, 0);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("abort_no_pulse", vcount[0] - vc, 0);
    send(0, 8'hFF, 8'h96);
    send(1, 8'h0F, 8'hF0);

    check("mosi_edge_viol0", viol[0], 0);
    check("mosi_edge_viol1", viol[1], 0);
    check("pulses_total0", vcount[0], 5);
    check("pulses_total1", vcount[1], 2);
    check("mosi_q_empty", exp_mosi.size(), 0);
    check("rx_q_empty", exp_rx.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
